// File: rtl/bus_step_sequencer_pkg.sv
// Shared definitions for the bus step sequencer: step-state codes, bus source
// codes, opcodes, opcode classes, IR field positions and the strobe bundle
// that the decoder hands to the top level.
package bus_step_sequencer_pkg;

  localparam int OPW  = 5;
  localparam int REGW = 4;

  // IR field LSB positions
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  // Step states
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Bus source codes
  localparam logic [3:0] BUS_NONE = 4'd0;
  localparam logic [3:0] BUS_RF   = 4'd1;
  localparam logic [3:0] BUS_PC   = 4'd2;
  localparam logic [3:0] BUS_MDR  = 4'd3;
  localparam logic [3:0] BUS_ZHI  = 4'd4;
  localparam logic [3:0] BUS_ZLO  = 4'd5;
  localparam logic [3:0] BUS_HI   = 4'd6;
  localparam logic [3:0] BUS_LO   = 4'd7;
  localparam logic [3:0] BUS_C    = 4'd8;
  localparam logic [3:0] BUS_PORT = 4'd9;

  // Opcodes
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // Opcode classes: instructions sharing one execute step pattern
  localparam logic [3:0] CL_LD   = 4'd0;
  localparam logic [3:0] CL_LDI  = 4'd1;
  localparam logic [3:0] CL_ST   = 4'd2;
  localparam logic [3:0] CL_RR   = 4'd3;
  localparam logic [3:0] CL_IMM  = 4'd4;
  localparam logic [3:0] CL_MD   = 4'd5;
  localparam logic [3:0] CL_NN   = 4'd6;
  localparam logic [3:0] CL_MFHI = 4'd7;
  localparam logic [3:0] CL_MFLO = 4'd8;
  localparam logic [3:0] CL_NOP  = 4'd9;
  localparam logic [3:0] CL_HALT = 4'd10;
  localparam logic [3:0] CL_ILL  = 4'd11;

  typedef struct packed {
    logic [3:0]      bus_src;
    logic [REGW-1:0] rf_sel;
    logic            rf_in;
    logic [REGW-1:0] rf_dst;
    logic            pc_in;
    logic            ir_in;
    logic            mar_in;
    logic            mdr_in;
    logic            y_in;
    logic            z_in;
    logic            hi_in;
    logic            lo_in;
    logic            inc_pc;
    logic [OPW-1:0]  alu_op;
    logic            mem_read;
    logic            mem_write;
    logic            halted;
    logic            illegal;
  } strobes_t;

  function automatic logic [3:0] op_class(input logic [OPW-1:0] op);
    logic [3:0] cls;
    cls = CL_ILL;
    if (op == OP_LD)                           cls = CL_LD;
    else if (op == OP_LDI)                     cls = CL_LDI;
    else if (op == OP_ST)                      cls = CL_ST;
    else if (op >= OP_ADD  && op <= OP_SHL)    cls = CL_RR;
    else if (op >= OP_ADDI && op <= OP_ORI)    cls = CL_IMM;
    else if (op == OP_DIV  || op == OP_MUL)    cls = CL_MD;
    else if (op == OP_NEG  || op == OP_NOT)    cls = CL_NN;
    else if (op == OP_MFHI)                    cls = CL_MFHI;
    else if (op == OP_MFLO)                    cls = CL_MFLO;
    else if (op == OP_NOP)                     cls = CL_NOP;
    else if (op == OP_HALT)                    cls = CL_HALT;
    return cls;
  endfunction

endpackage

// File: rtl/bus_step_sequencer_seq_decode.sv
// Combinational step decoder: current step + IR fields -> strobe bundle and
// next step. Holds no state.
// Ports:
//   i_state      current step state
//   i_opcode     IR[31:27]; i_ra/i_rb/i_rc register index fields
//   i_run        keep fetching at instruction boundaries
//   i_mem_ready  completion of the pending memory request
//   i_t1_again   this is a repeated (waiting) T1 cycle
//   o_strb       output strobes; o_next_state step for the next edge
module seq_decode
  import bus_step_sequencer_pkg::*;
(
  input  logic [3:0]      i_state,
  input  logic [OPW-1:0]  i_opcode,
  input  logic [REGW-1:0] i_ra,
  input  logic [REGW-1:0] i_rb,
  input  logic [REGW-1:0] i_rc,
  input  logic            i_run,
  input  logic            i_mem_ready,
  input  logic            i_t1_again,
  output strobes_t        o_strb,
  output logic [3:0]      o_next_state
);

  // Memory handshake: mem_read/mem_write stay high, and the step repeats,
  // until a cycle in which mem_ready is sampled high; that cycle completes
  // the transfer. mem_ready outside a request step is ignored.
  logic [3:0] w_cls;
  logic       w_last;
  logic       w_exec;

  always_comb begin
    o_strb       = '0;
    o_next_state = i_state;
    w_last       = 1'b0;
    w_cls        = op_class(i_opcode);
    w_exec       = 1'b0;
    case (i_state)
      S_IDLE: if (i_run) o_next_state = S_T0;
      S_T0: begin
        o_strb.bus_src = BUS_PC;
        o_strb.mar_in  = 1'b1;
        o_strb.inc_pc  = 1'b1;
        o_strb.z_in    = 1'b1;
        o_next_state   = S_T1;
      end
      S_T1: begin
        o_strb.bus_src  = BUS_ZLO;
        o_strb.pc_in    = ~i_t1_again;  // PC+1 loaded once, not per wait cycle
        o_strb.mem_read = 1'b1;
        o_strb.mdr_in   = 1'b1;
        if (i_mem_ready) o_next_state = S_T2;
      end
      S_T2: begin
        o_strb.bus_src = BUS_MDR;
        o_strb.ir_in   = 1'b1;
        o_next_state   = S_T3;
      end
      S_T3: begin
        w_exec       = 1'b1;
        o_next_state = S_T4;
        case (w_cls)
          CL_RR, CL_IMM, CL_LD, CL_ST: begin
            o_strb.bus_src = BUS_RF; o_strb.rf_sel = i_rb; o_strb.y_in = 1'b1;
          end
          CL_LDI: o_strb.y_in = 1'b1;  // nothing drives the bus: Y <= 0
          CL_MD: begin
            o_strb.bus_src = BUS_RF; o_strb.rf_sel = i_ra; o_strb.y_in = 1'b1;
          end
          CL_NN: begin
            o_strb.bus_src = BUS_RF; o_strb.rf_sel = i_rb; o_strb.z_in = 1'b1;
          end
          CL_MFHI, CL_MFLO: begin
            o_strb.bus_src = (w_cls == CL_MFHI) ? BUS_HI : BUS_LO;
            o_strb.rf_in   = 1'b1; o_strb.rf_dst = i_ra; w_last = 1'b1;
          end
          CL_NOP:  w_last = 1'b1;
          CL_HALT: o_next_state = S_HALT;
          default: begin
            o_strb.illegal = 1'b1; w_last = 1'b1;
          end
        endcase
      end
      S_T4: begin
        w_exec       = 1'b1;
        o_next_state = S_T5;
        case (w_cls)
          CL_RR: begin
            o_strb.bus_src = BUS_RF; o_strb.rf_sel = i_rc; o_strb.z_in = 1'b1;
          end
          CL_IMM, CL_LDI, CL_LD, CL_ST: begin
            o_strb.bus_src = BUS_C; o_strb.z_in = 1'b1;
          end
          CL_MD: begin
            o_strb.bus_src = BUS_RF; o_strb.rf_sel = i_rb; o_strb.z_in = 1'b1;
          end
          CL_NN: begin
            o_strb.bus_src = BUS_ZLO; o_strb.rf_in = 1'b1; o_strb.rf_dst = i_ra;
            w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_T5: begin
        w_exec       = 1'b1;
        o_next_state = S_T6;
        case (w_cls)
          CL_RR, CL_IMM, CL_LDI: begin
            o_strb.bus_src = BUS_ZLO; o_strb.rf_in = 1'b1; o_strb.rf_dst = i_ra;
            w_last = 1'b1;
          end
          CL_LD, CL_ST: begin
            o_strb.bus_src = BUS_ZLO; o_strb.mar_in = 1'b1;
          end
          CL_MD: begin
            o_strb.bus_src = BUS_ZLO; o_strb.lo_in = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_T6: begin
        w_exec       = 1'b1;
        o_next_state = S_T7;
        case (w_cls)
          CL_LD: begin
            o_strb.mem_read = 1'b1; o_strb.mdr_in = 1'b1;
            if (!i_mem_ready) o_next_state = S_T6;
          end
          CL_ST: begin
            o_strb.bus_src = BUS_RF; o_strb.rf_sel = i_ra; o_strb.mdr_in = 1'b1;
          end
          CL_MD: begin
            o_strb.bus_src = BUS_ZHI; o_strb.hi_in = 1'b1; w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_T7: begin
        w_exec = 1'b1;
        case (w_cls)
          CL_LD: begin
            o_strb.bus_src = BUS_MDR; o_strb.rf_in = 1'b1; o_strb.rf_dst = i_ra;
            w_last = 1'b1;
          end
          CL_ST: begin
            o_strb.mem_write = 1'b1;
            w_last = i_mem_ready;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_HALT:  o_strb.halted = 1'b1;
      default: o_next_state = S_IDLE;
    endcase

    // ALU function follows the opcode during execute steps only; halt and
    // undefined opcodes keep every output at zero.
    if (w_exec && w_cls != CL_ILL && w_cls != CL_HALT) o_strb.alu_op = i_opcode;

    // A finished instruction only re-enters fetch while run is high.
    if (w_last) o_next_state = i_run ? S_T0 : S_IDLE;
  end

endmodule

// File: rtl/bus_step_sequencer.sv
// Control-step sequencer for the shared 32-bit datapath bus. Fetches
// (T0-T2) and runs execute steps (T3-T7) for the opcode in IR[31:27],
// driving one encoded bus source plus register, ALU and memory strobes.
// Ports:
//   clock, reset_n (async, active low), run, ir[31:0], mem_ready
//   bus_src[3:0], rf_sel[3:0], rf_in, rf_dst[3:0], pc_in, ir_in, mar_in,
//   mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, alu_op[4:0], mem_read,
//   mem_write, halted, illegal
module bus_step_sequencer
  import bus_step_sequencer_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [3:0]      bus_src,
  output logic [REGW-1:0] rf_sel,
  output logic            rf_in,
  output logic [REGW-1:0] rf_dst,
  output logic            pc_in,
  output logic            ir_in,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            y_in,
  output logic            z_in,
  output logic            hi_in,
  output logic            lo_in,
  output logic            inc_pc,
  output logic [OPW-1:0]  alu_op,
  output logic            mem_read,
  output logic            mem_write,
  output logic            halted,
  output logic            illegal
);

  logic [3:0] r_state;
  logic       r_t1_again;
  logic [3:0] w_next_state;
  strobes_t   w_strb;
  logic       w_unused_ir;

  assign w_unused_ir = ^ir[IR_RC_LSB-1:0];  // offset field feeds the datapath only

  seq_decode u_decode (
    .i_state      (r_state),
    .i_opcode     (ir[IR_OP_LSB +: OPW]),
    .i_ra         (ir[IR_RA_LSB +: REGW]),
    .i_rb         (ir[IR_RB_LSB +: REGW]),
    .i_rc         (ir[IR_RC_LSB +: REGW]),
    .i_run        (run),
    .i_mem_ready  (mem_ready),
    .i_t1_again   (r_t1_again),
    .o_strb       (w_strb),
    .o_next_state (w_next_state)
  );

  // Outputs are pure decode of r_state, so the async reset forces them (and
  // any pending memory request) to zero without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_t1_again <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_t1_again <= (r_state == S_T1) && (w_next_state == S_T1);
    end
  end

  assign bus_src   = w_strb.bus_src;
  assign rf_sel    = w_strb.rf_sel;
  assign rf_in     = w_strb.rf_in;
  assign rf_dst    = w_strb.rf_dst;
  assign pc_in     = w_strb.pc_in;
  assign ir_in     = w_strb.ir_in;
  assign mar_in    = w_strb.mar_in;
  assign mdr_in    = w_strb.mdr_in;
  assign y_in      = w_strb.y_in;
  assign z_in      = w_strb.z_in;
  assign hi_in     = w_strb.hi_in;
  assign lo_in     = w_strb.lo_in;
  assign inc_pc    = w_strb.inc_pc;
  assign alu_op    = w_strb.alu_op;
  assign mem_read  = w_strb.mem_read;
  assign mem_write = w_strb.mem_write;
  assign halted    = w_strb.halted;
  assign illegal   = w_strb.illegal;

endmodule

// File: tb/tb_bus_step_sequencer.sv
// Directed bench for bus_step_sequencer. All outputs are packed into one
// 31-bit observation word and compared every cycle against hand-built words.
module tb_bus_step_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [3:0]  bus_src, rf_sel, rf_dst;
  logic        rf_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic        inc_pc, mem_read, mem_write, halted, illegal;
  logic [4:0]  alu_op;
  logic [30:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bus_step_sequencer dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .bus_src(bus_src), .rf_sel(rf_sel), .rf_in(rf_in), .rf_dst(rf_dst),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .inc_pc(inc_pc),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .halted(halted), .illegal(illegal)
  );

  assign obs = {bus_src, rf_sel, rf_in, rf_dst, pc_in, ir_in, mar_in, mdr_in,
                y_in, z_in, hi_in, lo_in, inc_pc, alu_op, mem_read, mem_write,
                halted, illegal};

  localparam logic [30:0] P_PC   = 31'd1 << 17;
  localparam logic [30:0] P_IR   = 31'd1 << 16;
  localparam logic [30:0] P_MAR  = 31'd1 << 15;
  localparam logic [30:0] P_MDR  = 31'd1 << 14;
  localparam logic [30:0] P_Y    = 31'd1 << 13;
  localparam logic [30:0] P_Z    = 31'd1 << 12;
  localparam logic [30:0] P_HI   = 31'd1 << 11;
  localparam logic [30:0] P_LO   = 31'd1 << 10;
  localparam logic [30:0] P_INC  = 31'd1 << 9;
  localparam logic [30:0] P_MR   = 31'd1 << 3;
  localparam logic [30:0] P_MW   = 31'd1 << 2;
  localparam logic [30:0] P_HALT = 31'd1 << 1;
  localparam logic [30:0] P_ILL  = 31'd1;

  // bus codes: 1 RF, 2 PC, 3 MDR, 4 ZHI, 5 ZLO, 8 C
  localparam logic [30:0] F0  = (31'd2 << 27) | P_MAR | P_INC | P_Z;
  localparam logic [30:0] F1  = (31'd5 << 27) | P_PC | P_MR | P_MDR;
  localparam logic [30:0] F1W = (31'd5 << 27) | P_MR | P_MDR;
  localparam logic [30:0] F2  = (31'd3 << 27) | P_IR;

  function automatic logic [30:0] bus(input int b);
    return 31'(b) << 27;
  endfunction
  function automatic logic [30:0] sel(input int r);
    return 31'(r) << 23;
  endfunction
  function automatic logic [30:0] dst(input int r);
    return (31'd1 << 22) | (31'(r) << 18);
  endfunction
  function automatic logic [30:0] alu(input int op);
    return 31'(op) << 4;
  endfunction
  function automatic logic [31:0] mk_ir(input int op, ra, rb, rc, imm);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'(imm)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; ir = '0; mem_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (obs !== 31'd0) begin
      $display("FAIL reset_outputs: got %h expected %h", obs, 31'd0); errors++;
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (obs !== 31'd0) begin
      $display("FAIL idle_run_low: got %h expected %h", obs, 31'd0); errors++;
    end
  endtask

  task automatic test_add();
    logic [30:0] e[$];
    logic        m[$];
    ir = mk_ir(3, 1, 2, 3, 0); run = 1'b1; mem_ready = 1'b1;
    tick();
    e = '{F0, F1, F2, bus(1)|sel(2)|P_Y|alu(3), bus(1)|sel(3)|P_Z|alu(3),
          bus(5)|dst(1)|alu(3)};
    m = '{1, 1, 1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL add step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
  endtask

  task automatic test_ld_wait();
    logic [30:0] e[$];
    logic        m[$];
    ir = mk_ir(0, 4, 0, 0, 16'h10);
    e = '{F0, F1, F1W, F2, bus(1)|P_Y, bus(8)|P_Z, bus(5)|P_MAR,
          P_MR|P_MDR, P_MR|P_MDR, P_MR|P_MDR, P_MR|P_MDR, bus(3)|dst(4)};
    m = '{1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL ld_wait step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
  endtask

  task automatic test_st_wait();
    logic [30:0] e[$];
    logic        m[$];
    ir = mk_ir(2, 7, 2, 0, 16'h20);
    e = '{F0, F1, F2, bus(1)|sel(2)|P_Y|alu(2), bus(8)|P_Z|alu(2),
          bus(5)|P_MAR|alu(2), bus(1)|sel(7)|P_MDR|alu(2),
          P_MW|alu(2), P_MW|alu(2), P_MW|alu(2)};
    m = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL st_wait step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
  endtask

  task automatic test_mul();
    logic [30:0] e[$];
    logic        m[$];
    ir = mk_ir(16, 5, 6, 0, 0);
    e = '{F0, F1, F2, bus(1)|sel(5)|P_Y|alu(16), bus(1)|sel(6)|P_Z|alu(16),
          bus(5)|P_LO|alu(16), bus(4)|P_HI|alu(16)};
    m = '{1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL mul step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
  endtask

  task automatic test_neg();
    logic [30:0] e[$];
    logic        m[$];
    ir = mk_ir(17, 3, 9, 0, 0);
    // mem_ready low outside a request must not stall T2..T4
    e = '{F0, F1, F2, bus(1)|sel(9)|P_Z|alu(17), bus(5)|dst(3)|alu(17)};
    m = '{1, 1, 0, 0, 0};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL neg step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [30:0] e[$];
    ir = mk_ir(31, 1, 2, 3, 0);
    e = '{F0, F1, F2, P_ILL, F0};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL illegal step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      if (i < e.size() - 1) tick();
    end
  endtask

  task automatic test_run_stop();
    logic [30:0] e[$];
    // in T0 already; run drops during fetch, nop still completes
    ir = mk_ir(26, 0, 0, 0, 0);
    e = '{F1, F2, alu(26), 31'd0, 31'd0};
    tick();
    for (int i = 0; i < e.size(); i++) begin
      run = 1'b0; mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL run_stop step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_ld();
    logic [30:0] e[$];
    ir = mk_ir(0, 4, 0, 0, 16'h10); run = 1'b1;
    tick();
    e = '{F0, F1, F2, bus(1)|P_Y, bus(8)|P_Z, bus(5)|P_MAR};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL rst_ld step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (obs !== (P_MR|P_MDR)) begin
      $display("FAIL rst_ld_t6: got %h expected %h", obs, P_MR|P_MDR); errors++;
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || obs !== 31'd0) begin
      $display("FAIL rst_async_drop: got %h expected %h", obs, 31'd0); errors++;
    end
    #1 reset_n = 1'b1;
    #1;
    checks++;
    if (obs !== 31'd0) begin
      $display("FAIL rst_release_idle: got %h expected %h", obs, 31'd0); errors++;
    end
    tick();
    checks++;
    if (obs !== F0) begin
      $display("FAIL rst_first_t0: got %h expected %h", obs, F0); errors++;
    end
  endtask

  task automatic test_halt();
    logic [30:0] e[$];
    logic        m[$];
    ir = mk_ir(27, 0, 0, 0, 0);
    e = '{F0, F1, F2, 31'd0, P_HALT, P_HALT, P_HALT};
    m = '{1, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL halt step %0d: got %h expected %h", i, obs, e[i]); errors++;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_ld_wait();
    test_st_wait();
    test_mul();
    test_neg();
    test_illegal();
    test_run_stop();
    test_reset_mid_ld();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
